// File: rtl/riscv_pkg.sv
// Shared fetch/decode types: word width, canonical NOP, and the fetch packet.
// Pure declarations, no logic; imported by the fetch-to-decode buffer.
// No flow control here; see if_id_buffer for handshake behaviour.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] inst;
        logic            misalign;
    } fetch_pkt_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Valid/ready word channel between pipeline stages; master produces, slave consumes.
// Combinational bundle, zero latency.
// Transfer happens on a clock edge where valid and ready are both high.
interface if_id_buffer_if;
    import riscv_pkg::*;

    logic            valid;
    logic            ready;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
    logic            misalign;

    // The producer of raw fetch words has no misalign opinion; the buffer derives it.
    modport master (output valid, output addr, output inst, output misalign, input ready);
    modport slave  (input valid, input addr, input inst, output ready);

endinterface

// File: rtl/if_id_buffer_skid_slot.sv
// Single-entry fetch packet register with load enable and valid bit.
// One cycle from ld to q/vld.
// No handshake; the owner decides when to load or clear.
module skid_slot
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic       clr,
    input  fetch_pkt_t d,
    output fetch_pkt_t q,
    output logic       vld
);

    // Clearing drops only the valid bit so stale data can still be observed when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (ld) begin
            vld <= 1'b1;
            q   <= d;
        end else if (clr) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode two-entry in-order skid buffer; IF_ID_BUBBLE_NOP_EN shows NOP/addr 0 when empty.
// Latency: word accepted at edge N is on the decode side after edge N.
// Backpressure: fe.ready depends on occupancy only; decode stall fills the skid entry.
module if_id_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    if_id_buffer_if.slave  fe,
    if_id_buffer_if.master de
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt;
    fetch_pkt_t    in_pkt;
    fetch_pkt_t    head_d;
    fetch_pkt_t    head_q;
    fetch_pkt_t    tail_q;
    logic          head_vld;
    logic          tail_vld;
    logic          push;
    logic          pop;
    logic          head_ld;
    logic          head_clr;
    logic          tail_ld;
    logic          tail_clr;
    logic [XLEN-1:0] head_addr;
    logic [XLEN-1:0] head_inst;

    assign fe.ready = (cnt != CW'(DEPTH));
    assign de.valid = (cnt != '0);

    assign push = fe.valid & fe.ready & ~flush;
    assign pop  = de.valid & de.ready & ~flush;

    always_comb begin
        in_pkt          = '0;
        in_pkt.addr     = fe.addr;
        in_pkt.inst     = fe.inst;
        in_pkt.misalign = is_misaligned(fe.addr);
    end

    // Head refills from tail on a pop when tail holds a word; otherwise from fetch.
    always_comb begin
        head_d   = (pop & tail_vld) ? tail_q : in_pkt;
        head_ld  = (push & ~head_vld) | (push & pop & ~tail_vld) | (pop & tail_vld);
        head_clr = flush | (pop & ~tail_vld & ~push);
        tail_ld  = push & head_vld & ~pop;
        tail_clr = flush | (pop & tail_vld);
    end

    skid_slot u_head (
        .clk (clk),
        .rst (rst),
        .ld  (head_ld),
        .clr (head_clr),
        .d   (head_d),
        .q   (head_q),
        .vld (head_vld)
    );

    skid_slot u_tail (
        .clk (clk),
        .rst (rst),
        .ld  (tail_ld),
        .clr (tail_clr),
        .d   (in_pkt),
        .q   (tail_q),
        .vld (tail_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_addr = head_q.addr;
    assign head_inst = head_q.inst;

`ifdef IF_ID_BUBBLE_NOP_EN
    assign de.addr     = de.valid ? head_addr : '0;
    assign de.inst     = de.valid ? head_inst : NOP_INST;
    assign de.misalign = de.valid & head_q.misalign;
`else
    assign de.addr     = head_addr;
    assign de.inst     = head_inst;
    assign de.misalign = head_q.misalign;
`endif

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Receiving end of the fetch-to-decode interface: accepts `{addr, inst}` pairs from the fetch stage and presents them to the decode stage. A two-entry in-order skid buffer with valid/ready handshakes on both sides. Absorbs one cycle of decode stall without dropping a fetched word, and discards everything in flight on a branch/jump flush.

## Interface
Parameters:
- `XLEN`, default 32: width of address and instruction.
- `DEPTH`, default 2: buffer entries; fixed at 2, other values unsupported.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_valid`  in  1  fetch presents a word this cycle.
- `if_addr`  in  XLEN  PC of presented word.
- `if_inst`  in  XLEN  instruction at `if_addr`.
- `if_ready`  out  1  buffer can accept this cycle.
- `id_valid`  out  1  head entry valid.
- `id_addr`  out  XLEN  PC of head entry.
- `id_inst`  out  XLEN  instruction of head entry.
- `id_misalign`  out  1  head entry's `addr[1:0] != 0`.
- `id_ready`  in  1  decode consumes head this cycle; low means stall.
- `flush`  in  1  redirect; discard all entries.

## Operation
- Occupancy counter `cnt` in 0..2. Head and tail slots are registers.
- Push: `if_valid & if_ready & ~flush`. Pop: `id_valid & id_ready`.
- `if_ready = (cnt != 2)`, a function of registered state only. No combinational path from `id_ready`.
- `id_valid = (cnt != 0)`. `id_addr`, `id_inst` and `id_misalign` come from the head slot.
- Next-state updates:
  - Push only: `cnt+1`; data written to the first free slot.
  - Pop only: `cnt-1`; tail moves to head.
  - Push and pop with `cnt==1`: head is loaded with the incoming word; `cnt` stays 1.
  - Push and pop with `cnt==2`: this cannot occur, because `if_ready` is low.
- Misalign flag is captured at push from `if_addr[1:0]` and travels with the entry.
- Entries leave in strict FIFO order. There is no reordering and no duplication.

## Timing
- Reset values:
  - `cnt=0`, `id_valid=0`, `id_addr=0`, `id_misalign=0`, `if_ready=1`.
  - `id_inst=0`, or NOP when `IF_ID_BUBBLE_NOP_EN` is defined.
- Pushes presented while `rst` is high are ignored.
- Latency: a word accepted at edge N appears on `id_*` with `id_valid=1` after edge N, i.e. one cycle.
- Throughput: one word per cycle while `id_ready` stays high.
- Full: with `cnt==2`, `if_ready=0`. The fetch stage must hold `if_addr`/`if_inst` stable until accepted.
- Empty: with `cnt==0`, `id_valid=0`. `id_ready` is ignored.
- Flush:
  - Highest priority. `cnt` becomes 0 at the next edge.
  - A push or pop in the same cycle is cancelled; the incoming word is dropped.
  - `id_valid=0` in the following cycle.
- `flush` and `rst` together: reset wins; the result is identical.
- Reset during a stall: all entries are discarded; `if_ready=1` after the edge.

## Configuration
- `IF_ID_BUBBLE_NOP_EN` defined:
  - When `cnt==0`, after flush, or at reset, `id_inst` reads `NOP_INST` (`32'h00000013`) and `id_addr` reads 0.
  - Decode may then ignore `id_valid` for side-effect suppression.
- Undefined:
  - `id_addr` and `id_inst` hold the last head contents when empty.
  - Only `id_valid` qualifies them.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`.
  - `NOP_INST`.
  - typedef `fetch_pkt_t` `{addr, inst, misalign}`, used by both fetch and this block.
- One sub-module is natural: `skid_slot`, a single-entry register with load enable and valid bit, instantiated twice (head, tail).
- Counter and control live in `if_id_buffer`.

## Test plan
- Streaming, no stall: push `0x00/0x00500093`, `0x04/0x00100113`, `0x08/0x002081b3` on consecutive cycles with `id_ready=1`. Required: each appears exactly one cycle later in order; `if_ready` stays 1.
- Stall fill: `id_ready=0`, push `0x10` then `0x14`. Required: `cnt=2` and `if_ready=0`. Then raise `id_ready` and require `0x10` and `0x14` on consecutive cycles, no loss or duplication.
- Simultaneous push and pop at `cnt==1`: head `0x20`, push `0x24` while popping. Required: next cycle head is `0x24`, `cnt=1`.
- Flush with push: `cnt=2` (`0x30`, `0x34`), assert `flush` with `if_valid=1` at `0x38`. Required: next cycle `id_valid=0`, `if_ready=1`, and `0x38` never appears.
- Misaligned address: push `if_addr=0x42`. Required: `id_misalign=1` with `id_addr=0x42`; the following push at `0x44` shows `id_misalign=0`.
- Reset mid-stall: `cnt=2`, assert `rst` one cycle. Required: `id_valid=0`, `id_addr=0`, `if_ready=1`, and `id_inst=0x00000013` when the macro is defined (else 0).
